// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Purpose  : Programmable down-counting timer. A load captures a period and
//            the timer counts it down to zero on enabled falling edges of
//            NEclk, pulsing `expired` when the count runs out. With
//            auto_reload set at expiry the captured period is reloaded with
//            no dead cycle, producing a periodic tick; `wraps` counts these
//            reloads since the last load.
//
// Ports    : NEclk       in  1          clock, all state updates on falling edge
//            reset       in  1          asynchronous, active-high reset
//            load        in  1          capture `period` and start the timer
//            period      in  BITS       timer period in clock cycles
//            stop        in  1          abort the timer (beats load)
//            Enable      in  1          active-low count enable
//            auto_reload in  1          reload the period at expiry
//            count       out BITS       remaining cycles
//            busy        out 1          timer running or paused
//            paused      out 1          timer paused
//            expired     out 1          one-cycle expiry pulse
//            wraps       out WRAP_BITS  auto-reload expiries since last load
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
  parameter int BITS      = 29,
  parameter int WRAP_BITS = 8
) (
  input  logic                 NEclk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BITS-1:0]      period,
  input  logic                 stop,
  input  logic                 Enable,
  input  logic                 auto_reload,
  output logic [BITS-1:0]      count,
  output logic                 busy,
  output logic                 paused,
  output logic                 expired,
  output logic [WRAP_BITS-1:0] wraps
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [BITS-1:0]      C_COUNT_ONE = BITS'(1);
  localparam logic [WRAP_BITS-1:0] C_WRAP_ONE  = WRAP_BITS'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [BITS-1:0]      r_count;
  logic [BITS-1:0]      r_reload_val;
  logic [WRAP_BITS-1:0] r_wraps;
  logic                 r_expired;
  logic                 r_busy;
  logic                 r_paused;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic [1:0]           w_state_nxt;
  logic [BITS-1:0]      w_count_nxt;
  logic [BITS-1:0]      w_reload_nxt;
  logic [WRAP_BITS-1:0] w_wraps_nxt;
  logic                 w_expired_nxt;
  logic                 w_count_gt_one;
  logic                 w_period_zero;
  logic                 w_enabled;

  assign w_count_gt_one = (r_count > C_COUNT_ONE);
  assign w_period_zero  = (period == '0);
  assign w_enabled      = ~Enable;   // Enable is active-low

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: stop > load > count/hold.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload_val;
    w_wraps_nxt   = r_wraps;
    w_expired_nxt = 1'b0;

    if (stop) begin
      // Abort: wraps is deliberately preserved so software can still read
      // how many periods elapsed before the abort.
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if (load) begin
      // A load never decrements on its own edge, and it also swallows an
      // expiry that would have happened on the same edge.
      w_reload_nxt = period;
      w_wraps_nxt  = '0;
      if (w_period_zero) begin
        // Zero-length period expires immediately without entering RUN.
        w_state_nxt   = ST_IDLE;
        w_count_nxt   = '0;
        w_expired_nxt = 1'b1;
      end else begin
        w_count_nxt = period;
        w_state_nxt = w_enabled ? ST_RUN : ST_PAUSE;
      end
    end else begin
      case (r_state)
        ST_RUN, ST_PAUSE: begin
          if (!w_enabled) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_count_gt_one) begin
            w_count_nxt = r_count - C_COUNT_ONE;
            w_state_nxt = ST_RUN;
          end else begin
            // count is 1 here: count never reads 0 while RUN/PAUSE, so this
            // branch is the expiry and no underflow is possible.
            w_expired_nxt = 1'b1;
            if (auto_reload) begin
              // Reload directly into count so the next period starts on
              // this very edge (no dead cycle between pulses).
              w_count_nxt = r_reload_val;
              w_state_nxt = ST_RUN;
              w_wraps_nxt = r_wraps + C_WRAP_ONE;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          // Enable and auto_reload are ignored while idle.
          w_count_nxt = '0;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers: falling edge of NEclk, asynchronous reset.
  // busy/paused are registered from the next state so every output is a
  // flop output rather than a decode of the state register.
  // --------------------------------------------------------------------------
  always_ff @(negedge NEclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_reload_val <= '0;
      r_wraps      <= '0;
      r_expired    <= 1'b0;
      r_busy       <= 1'b0;
      r_paused     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_reload_val <= w_reload_nxt;
      r_wraps      <= w_wraps_nxt;
      r_expired    <= w_expired_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_paused     <= (w_state_nxt == ST_PAUSE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count   = r_count;
  assign busy    = r_busy;
  assign paused  = r_paused;
  assign expired = r_expired;
  assign wraps   = r_wraps;

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer that complements the free-running up-counter blocks: instead of accumulating a count, it loads a period and counts it down to zero, flagging expiry. Used wherever the design needs a fixed number of clock periods to elapse (delays, timeouts, periodic ticks), with optional auto-reload for periodic operation. All logic runs on the falling edge of `NEclk`, like the rest of the counter blocks.

## Interface

- `BITS`, default 29: width of the period and count.
- `WRAP_BITS`, default 8: width of the reload (wrap) counter.

- `NEclk`  in  1: clock; all state updates on the falling edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: sampled at falling edge; when 1, captures `period` and starts the timer.
- `period`  in  BITS: timer period in clock cycles; valid when `load`=1.
- `stop`  in  1: sampled; when 1, aborts the timer.
- `Enable`  in  1: active-low count enable; counting occurs only on edges where `Enable`=0.
- `auto_reload`  in  1: when 1 at expiry, the timer reloads the captured period and keeps running.
- `count`  out  BITS: remaining cycles.
- `busy`  out  1: 1 in RUN or PAUSE.
- `paused`  out  1: 1 in PAUSE.
- `expired`  out  1: one-cycle pulse on expiry.
- `wraps`  out  WRAP_BITS: number of auto-reload expiries since the last load, modulo 2^WRAP_BITS.

## Operation

- States: IDLE, RUN, PAUSE. Internal register `reload_val` (BITS) holds the last captured period.
- Reset (asynchronous, any time): state IDLE; `count`=0; `reload_val`=0; `wraps`=0; `expired`=0; `busy`=0; `paused`=0.
- Per-edge priority: `reset` > `stop` > `load` > count/hold.
- `stop`=1: state IDLE, `count`=0, `wraps` unchanged, no `expired` pulse. This also overrides a `load` on the same edge.
- `load`=1 (any state): `reload_val`←`period`, `wraps`←0, and no decrement on this edge.
  - If `period`=0: `count`=0, state IDLE, and `expired` pulses once.
  - Otherwise: `count`←`period`, and the state becomes RUN if `Enable`=0, PAUSE if `Enable`=1.
- In RUN or PAUSE, with no `stop` or `load`:
  - `Enable`=1: `count` holds; state PAUSE.
  - `Enable`=0 and `count`>1: `count`←`count`−1; state RUN.
  - `Enable`=0 and `count`=1: expiry. `expired`←1 for exactly one cycle.
    - If `auto_reload`=1: `count`←`reload_val`, state stays RUN, `wraps`←`wraps`+1 (wraps modulo 2^WRAP_BITS).
    - If `auto_reload`=0: `count`←0, state IDLE.
- IDLE with no `load`: `count` holds 0. `Enable` and `auto_reload` are ignored.
- Arithmetic: the decrement is unsigned, BITS wide, and never goes below 0 (the `count`=1 rule prevents underflow). `count` never reads 0 while RUN/PAUSE.
- `auto_reload` is sampled only on the expiry edge, so changing it mid-count is legal.

## Timing

- All outputs are registered and change only on the falling edge of `NEclk`, or asynchronously on `reset`.
- Latency: with `load` at edge k, `period`=N≥1, and `Enable` held 0, `count` reads N after edge k and N−j after edge k+j. `expired` is high from edge k+N to edge k+N+1.
- Auto-reload period: successive `expired` pulses are exactly N edges apart. There is no dead cycle at reload.
- Pausing: each edge with `Enable`=1 delays expiry by exactly one edge.
- `load` on the same edge as an expiry: the load wins, with no `expired` pulse and `wraps`=0.
- `expired` and `busy` may both be 1 in the same cycle (auto-reload); `busy`=0 in the cycle after a non-reload expiry.

## Test plan

- Reset mid-count: `reset` asserted between clock edges while `count`=5 -> all outputs 0 immediately, without waiting for a clock edge.
- One-shot: load with `period`=4, `auto_reload`=0, `Enable`=0 -> `count` reads 4,3,2,1,0. `expired` is high for one cycle, coinciding with `count`=0. `busy` falls with it.
- Auto-reload: load `period`=3, `auto_reload`=1, 10 edges with `Enable`=0 -> `expired` pulses at edges 3, 6, 9; `count` sequence 3,2,1,3,2,1,3,2,1,3,2; `wraps`=3.
- Pause: load `period`=3, `Enable` toggled 0,1,1,0,0 -> `count` reads 3,2,2,2,1,3 at edges 0..5 (edge 5 with `Enable`=0). `paused`=1 only after edges 2 and 3. Expiry is delayed by 2 edges.
- Zero and overrides: load `period`=0 -> one `expired` pulse, `busy`=0. Load on an expiry edge -> no pulse, `count`=new period. `stop`+`load` on the same edge -> IDLE, `count`=0.
- Width: `BITS`=29, load `period`=2^29−1 -> first decrement gives 2^29−2, and `count` never wraps on reload.
